// File: rtl/ivl_uvm_sampler_pkg.sv
// Shared types and sizing helpers for the ivl_uvm transaction sampler.
package ivl_uvm_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    STOPPED = 2'd3
  } sampler_state_e;

  localparam int DROP_CNT_W = 16;
  localparam int CAPT_CNT_W = 32;

  // A stored entry is {payload, timestamp}, packed MSB-first.
  function automatic int entry_w(input int data_w, input int ts_w);
    return data_w + ts_w;
  endfunction

endpackage

// File: rtl/ivl_uvm_sampler_fifo.sv
// Show-ahead synchronous FIFO: the head entry is read combinationally from storage.
module ivl_uvm_sampler_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff;
  logic             push_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_eff  = pop && !empty && !clear;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign push_eff = push && !clear && (!full || pop_eff);
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ivl_uvm_txn_sampler.sv
// Capture stage: samples accepted valid/ready transfers inside an arm/trigger/stop
// window, timestamps them and queues them for the monitor.
module ivl_uvm_txn_sampler
  import ivl_uvm_sampler_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 32,
  parameter int MAX_CAPT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     trig,
  input  logic                     stop,
  input  logic                     clear,
  input  logic                     mon_valid,
  input  logic                     mon_ready,
  input  logic [DATA_W-1:0]        mon_data,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  output sampler_state_e           state
);

  localparam int ENTRY_W = entry_w(DATA_W, TS_W);

  sampler_state_e          state_q, state_d;
  logic [TS_W-1:0]         ts_q;
  logic [CAPT_CNT_W-1:0]   capt_cnt_q, capt_cnt_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                    overflow_q, overflow_d;

  logic                    below_lim;
  logic                    lim_hit_d;
  logic                    capture;
  logic                    push;
  logic                    drop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ENTRY_W-1:0]      head;

  generate
    if (MAX_CAPT == 0) begin : g_unlimited
      assign below_lim = 1'b1;
      assign lim_hit_d = 1'b0;
    end else begin : g_limited
      localparam logic [CAPT_CNT_W-1:0] MAX_CAPT_V = CAPT_CNT_W'(MAX_CAPT);
      assign below_lim = (capt_cnt_q < MAX_CAPT_V);
      assign lim_hit_d = (capt_cnt_d >= MAX_CAPT_V);
    end
  endgenerate

  // The trigger cycle itself is sampled, so ARMED+trig opens the window immediately.
  assign capture = ((state_q == CAPTURE) || (state_q == ARMED && trig && !stop))
                   && mon_valid && mon_ready && below_lim;
  assign push    = capture && !clear && (!fifo_full || pop);
  assign drop    = capture && !clear && fifo_full && !pop;

  ivl_uvm_sampler_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .wr_data ({mon_data, ts_q}),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    capt_cnt_d = capt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clear) begin
      capt_cnt_d = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (push && capt_cnt_q != '1) capt_cnt_d = capt_cnt_q + 1'b1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = STOPPED;
    end else begin
      case (state_q)
        IDLE:    if (arm)       state_d = ARMED;
        ARMED:   if (trig)      state_d = lim_hit_d ? STOPPED : CAPTURE;
        CAPTURE: if (lim_hit_d) state_d = STOPPED;
        STOPPED: if (arm)       state_d = ARMED;
        default:                state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      capt_cnt_q <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_q + 1'b1;
      capt_cnt_q <= capt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign out_data  = head[ENTRY_W-1 -: DATA_W];
  assign out_ts    = head[TS_W-1:0];
  assign full      = fifo_full;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ivl_uvm_txn_sampler.sv
// Self-checking bench: an unlimited and a MAX_CAPT=4 sampler share one stimulus
// stream and are compared every cycle against a list-based reference model.
module tb_ivl_uvm_txn_sampler;
  import ivl_uvm_sampler_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0, trig = 1'b0, stop = 1'b0, clear = 1'b0;
  logic          mon_valid = 1'b0, mon_ready = 1'b0, pop = 1'b0;
  logic [DW-1:0] mon_data = '0;

  logic           ov_w   [2];
  logic [DW-1:0]  od_w   [2];
  logic [TW-1:0]  ots_w  [2];
  logic [CW-1:0]  cnt_w  [2];
  logic           full_w [2];
  logic           ovf_w  [2];
  logic [15:0]    drop_w [2];
  sampler_state_e st_w   [2];

  always #5 clk = ~clk;

  ivl_uvm_txn_sampler #(.DATA_W(DW), .DEPTH(DEPTH), .TS_W(TW), .MAX_CAPT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig(trig), .stop(stop), .clear(clear),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_data(mon_data), .pop(pop),
    .out_valid(ov_w[0]), .out_data(od_w[0]), .out_ts(ots_w[0]), .count(cnt_w[0]),
    .full(full_w[0]), .overflow(ovf_w[0]), .drop_cnt(drop_w[0]), .state(st_w[0]));

  ivl_uvm_txn_sampler #(.DATA_W(DW), .DEPTH(DEPTH), .TS_W(TW), .MAX_CAPT(4)) u_dut_lim (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig(trig), .stop(stop), .clear(clear),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_data(mon_data), .pop(pop),
    .out_valid(ov_w[1]), .out_data(od_w[1]), .out_ts(ots_w[1]), .count(cnt_w[1]),
    .full(full_w[1]), .overflow(ovf_w[1]), .drop_cnt(drop_w[1]), .state(st_w[1]));

  // Reference model: each instance holds an ordered list of entries (index 0 = head).
  logic [DW-1:0]  md [2][DEPTH];
  logic [TW-1:0]  mt [2][DEPTH];
  int             ml [2];
  int             mcc [2];
  int             mdrop [2];
  bit             movf [2];
  sampler_state_e mst [2];
  logic [TW-1:0]  mts;

  int compared = 0;
  int mismatched = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ml[i] = 0; mcc[i] = 0; mdrop[i] = 0; movf[i] = 1'b0; mst[i] = IDLE;
    end
    mts = '0;
  endtask

  task automatic model_step(input int i, input int max_capt);
    bit cap, lim;
    cap = (mst[i] == CAPTURE || (mst[i] == ARMED && trig && !stop))
          && mon_valid && mon_ready && (max_capt == 0 || mcc[i] < max_capt);
    if (clear) begin
      ml[i] = 0; mcc[i] = 0; mdrop[i] = 0; movf[i] = 1'b0;
    end else begin
      if (pop && ml[i] > 0) begin
        for (int k = 0; k < DEPTH - 1; k++) begin
          md[i][k] = md[i][k+1];
          mt[i][k] = mt[i][k+1];
        end
        ml[i] = ml[i] - 1;
      end
      if (cap) begin
        if (ml[i] < DEPTH) begin
          md[i][ml[i]] = mon_data;
          mt[i][ml[i]] = mts;
          ml[i] = ml[i] + 1;
          mcc[i] = mcc[i] + 1;
        end else begin
          movf[i] = 1'b1;
          if (mdrop[i] < 65535) mdrop[i] = mdrop[i] + 1;
        end
      end
    end
    lim = (max_capt != 0) && (mcc[i] >= max_capt);
    if (stop) mst[i] = STOPPED;
    else begin
      case (mst[i])
        IDLE:    if (arm)  mst[i] = ARMED;
        ARMED:   if (trig) mst[i] = lim ? STOPPED : CAPTURE;
        CAPTURE: if (lim)  mst[i] = STOPPED;
        STOPPED: if (arm)  mst[i] = ARMED;
        default: mst[i] = IDLE;
      endcase
    end
  endtask

  task automatic chk(input int i, input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL u%0d.%s at %0t: observed %0h expected %0h", i, name, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk(i, "out_valid", 64'(ov_w[i]),   64'(ml[i] > 0));
      chk(i, "out_data",  64'(od_w[i]),   ml[i] > 0 ? 64'(md[i][0]) : 64'd0);
      chk(i, "out_ts",    64'(ots_w[i]),  ml[i] > 0 ? 64'(mt[i][0]) : 64'd0);
      chk(i, "count",     64'(cnt_w[i]),  64'(ml[i]));
      chk(i, "full",      64'(full_w[i]), 64'(ml[i] == DEPTH));
      chk(i, "overflow",  64'(ovf_w[i]),  64'(movf[i]));
      chk(i, "drop_cnt",  64'(drop_w[i]), 64'(mdrop[i]));
      chk(i, "state",     64'(st_w[i]),   64'(mst[i]));
    end
  endtask

  // One clock: model advances on the edge using the inputs the DUT sees, outputs checked mid-cycle.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) begin
      model_step(0, 0);
      model_step(1, 4);
      mts = mts + 1'b1;
    end else begin
      model_reset();
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic xfer(input logic [DW-1:0] d);
    mon_valid = 1'b1; mon_ready = 1'b1; mon_data = d;
    cyc();
    mon_valid = 1'b0; mon_ready = 1'b0;
  endtask

  task automatic pulse_arm();   arm = 1'b1;   cyc(); arm = 1'b0;   endtask
  task automatic pulse_stop();  stop = 1'b1;  cyc(); stop = 1'b0;  endtask
  task automatic pulse_clear(); clear = 1'b1; cyc(); clear = 1'b0; endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    cycles(2);
    rst_n = 1'b1;

    // Basic capture of three transfers with a gap, then drain.
    pulse_arm();
    trig = 1'b1;
    cycles(1);
    xfer(32'hA1);
    xfer(32'hA2);
    cycles(2);
    xfer(32'hA3);
    trig = 1'b0;
    pop = 1'b1;
    cycles(4);
    pop = 1'b0;

    // Overfill: 20 back-to-back transfers with no pop.
    pulse_clear();
    mon_valid = 1'b1; mon_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      mon_data = 32'h1000 + k;
      cyc();
    end
    // Push and pop together while full.
    mon_data = 32'hBEEF; pop = 1'b1;
    cyc();
    mon_valid = 1'b0; mon_ready = 1'b0;
    cycles(17);
    pop = 1'b0;

    // Auto-stop window on the MAX_CAPT=4 instance with continuous traffic.
    pulse_stop();
    pulse_clear();
    pulse_arm();
    trig = 1'b1; mon_valid = 1'b1; mon_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mon_data = 32'h2000 + k;
      cyc();
    end
    trig = 1'b0; mon_valid = 1'b0; mon_ready = 1'b0;
    pop = 1'b1;
    cycles(12);
    pop = 1'b0;

    // stop beats arm while ARMED; untriggered traffic is ignored.
    pulse_stop();
    pulse_arm();
    stop = 1'b1; arm = 1'b1;
    cyc();
    stop = 1'b0; arm = 1'b0;
    pulse_arm();
    mon_valid = 1'b1; mon_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mon_data = 32'h3000 + k;
      cyc();
    end

    // Five entries mid-capture, then clear with a concurrent transfer.
    trig = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mon_data = 32'h4000 + k;
      cyc();
    end
    trig = 1'b0;
    mon_data = 32'h4FFF; clear = 1'b1;
    cyc();
    clear = 1'b0; mon_valid = 1'b0; mon_ready = 1'b0;
    xfer(32'h4ABC);
    xfer(32'h4ABD);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    cyc();
    rst_n = 1'b1;
    pulse_arm();
    trig = 1'b1;
    xfer(32'h5A5A);
    trig = 1'b0;
    pop = 1'b1;
    cyc();
    pop = 1'b0;

    // Randomized traffic with varying drain rates.
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 150; k++) begin
        arm       = ($urandom_range(0, 11) == 0);
        trig      = ($urandom_range(0, 2) != 0);
        stop      = ($urandom_range(0, 39) == 0);
        clear     = ($urandom_range(0, 59) == 0);
        mon_valid = ($urandom_range(0, 3) != 0);
        mon_ready = ($urandom_range(0, 3) != 0);
        mon_data  = $urandom;
        pop       = ($urandom_range(0, 3) < ph);
        cyc();
      end
    end
    arm = 1'b0; trig = 1'b0; stop = 1'b0; clear = 1'b0;
    mon_valid = 1'b0; mon_ready = 1'b0; pop = 1'b0;
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
